mdu_unit: RTL and testbench

//  Multiply/divide unit in the E stage, directly downstream of the register file read ports.

---
 rtl/mdu_unit_pkg.sv | 28 ++
 rtl/mdu_unit_if.sv | 16 +
 rtl/mdu_unit.sv | 112 +++++++++++
 tb/tb_mdu_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_unit_pkg.sv
// Shared constants for the E-stage multiply/divide unit: OP encodings and widths.
package mdu_unit_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [OP_W-1:0] {
        MDU_NOP   = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;

    // Multi-cycle ops are the ones that raise BUSY
    function automatic logic is_long_op(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    function automatic logic is_div_op(input mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// Issue/result bundle between the E-stage datapath and the multiply/divide unit.
interface mdu_unit_if;
    import mdu_unit_pkg::*;

    logic              START;
    logic [OP_W-1:0]   OP;
    logic [WORD_W-1:0] A;
    logic [WORD_W-1:0] B;
    logic              BUSY;
    logic [WORD_W-1:0] HI;
    logic [WORD_W-1:0] LO;

    modport master (output START, OP, A, B, input BUSY, HI, LO);
    modport slave  (input START, OP, A, B, output BUSY, HI, LO);

endinterface

// File: rtl/mdu_unit.sv
// Multiply/divide unit: computes the result at issue into pending registers,
// holds BUSY for a fixed cycle count, then commits to HI/LO.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       RESET_N,
    mdu_unit_if.slave  mdu
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_op_e           op;
    logic              busy;
    logic              accept;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  n_load;

    logic [WORD_W-1:0] hi_q, lo_q;
    logic [WORD_W-1:0] p_hi, p_lo;
    logic              p_wr;

    logic [WORD_W-1:0] res_hi, res_lo;
    logic              res_wr;

    logic signed [WORD_W:0] mul_a, mul_b;
    logic [2*WORD_W-1:0]    prod;
    logic                   a_neg, b_neg, sdiv;
    logic [WORD_W-1:0]      div_n, div_d, quo, rem;

    assign op     = mdu_op_e'(mdu.OP);
    assign busy   = (cnt != '0);
    assign accept = mdu.START && !busy;

    // One 33x33 signed multiplier serves both MULT (sign-extend) and MULTU (zero-extend);
    // one unsigned divider serves both DIV (on magnitudes, signs fixed after) and DIVU.
    always_comb begin
        mul_a = {(op == MDU_MULT) & mdu.A[WORD_W-1], mdu.A};
        mul_b = {(op == MDU_MULT) & mdu.B[WORD_W-1], mdu.B};
        prod  = 64'(mul_a) * 64'(mul_b);

        sdiv  = (op == MDU_DIV);
        a_neg = sdiv & mdu.A[WORD_W-1];
        b_neg = sdiv & mdu.B[WORD_W-1];
        div_n = a_neg ? -mdu.A : mdu.A;
        div_d = b_neg ? -mdu.B : mdu.B;
        if (div_d == '0) begin
            div_d = WORD_W'(1);
        end
        quo = div_n / div_d;
        rem = div_n % div_d;
    end

    // Select the pending result and the counter load for the issued op
    always_comb begin
        res_hi = '0;
        res_lo = '0;
        res_wr = 1'b0;
        n_load = '0;
        if (is_div_op(op)) begin
            res_lo = (a_neg ^ b_neg) ? -quo : quo;
            res_hi = a_neg ? -rem : rem;
            res_wr = (mdu.B != '0);
            n_load = CNT_W'(DIV_CYCLES);
        end else if (is_long_op(op)) begin
            res_hi = prod[2*WORD_W-1:WORD_W];
            res_lo = prod[WORD_W-1:0];
            res_wr = 1'b1;
            n_load = CNT_W'(MULT_CYCLES);
        end
    end

    // Issue, countdown and commit of HI/LO
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt  <= '0;
            hi_q <= '0;
            lo_q <= '0;
            p_hi <= '0;
            p_lo <= '0;
            p_wr <= 1'b0;
        end else if (accept) begin
            if (is_long_op(op)) begin
                cnt  <= n_load;
                p_hi <= res_hi;
                p_lo <= res_lo;
                p_wr <= res_wr;
            end
            if (op == MDU_MTHI) begin
                hi_q <= mdu.A;
            end
            if (op == MDU_MTLO) begin
                lo_q <= mdu.A;
            end
        end else if (busy) begin
            cnt <= cnt - CNT_W'(1);
            if ((cnt == CNT_W'(1)) && p_wr) begin
                hi_q <= p_hi;
                lo_q <= p_lo;
            end
        end
    end

    assign mdu.BUSY = busy;
    assign mdu.HI   = hi_q;
    assign mdu.LO   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed cases plus random ops against
// an arithmetic reference model of HI/LO and BUSY length.
module tb_mdu_unit;
    import mdu_unit_pkg::*;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mdu_unit_if bus();

    mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .RESET_N (rst_n),
        .mdu     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned exp_busy(input logic [2:0] op);
        case (op)
            3'd1, 3'd2: return MC;
            3'd3, 3'd4: return DC;
            default:    return 0;
        endcase
    endfunction

    // Reference: architectural effect of one op, using 64-bit arithmetic
    task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sp, sa, sb, q, r;
        logic [63:0] up;
        case (mdu_op_e'(op))
            MDU_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                m_hi = sp[63:32];
                m_lo = sp[31:0];
            end
            MDU_MULTU: begin
                up = 64'(a) * 64'(b);
                m_hi = up[63:32];
                m_lo = up[31:0];
            end
            MDU_DIV: if (b != 0) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q  = sa / sb;
                r  = sa % sb;
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            MDU_DIVU: if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            MDU_MTHI: m_hi = a;
            MDU_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb);
        int          n;
        logic [31:0] old_hi, old_lo;
        old_hi = m_hi;
        old_lo = m_lo;
        @(negedge clk);
        bus.START = 1'b1;
        bus.OP    = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        bus.START = 1'b0;
        bus.OP    = 3'd0;
        if (disturb) begin
            bus.A = $urandom;
            bus.B = $urandom;
        end
        n = 0;
        while (bus.BUSY === 1'b1 && n < 200) begin
            if (n == 0) begin
                check("hold_hi", bus.HI, old_hi);
                check("hold_lo", bus.LO, old_lo);
            end
            if (disturb) begin
                bus.START = 1'b1;
                bus.OP    = 3'd1;
                bus.A     = $urandom;
                bus.B     = $urandom;
            end
            @(posedge clk);
            #1;
            bus.START = 1'b0;
            n++;
        end
        model_apply(op, a, b);
        check("busy_len", 32'(n), 32'(exp_busy(op)));
        check("hi", bus.HI, m_hi);
        check("lo", bus.LO, m_lo);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        bus.START = 1'b0;
        bus.OP    = 3'd0;
        bus.A     = '0;
        bus.B     = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_hi", bus.HI, 32'd0);
        check("rst_lo", bus.LO, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // async reset in the middle of a MULT
        run_op(3'd5, 32'h55, 32'h0, 1'b0);
        @(negedge clk);
        bus.START = 1'b1; bus.OP = 3'd1; bus.A = 32'd3; bus.B = 32'd4;
        @(posedge clk);
        #1;
        bus.START = 1'b0; bus.OP = 3'd0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        check("arst_busy", 32'(bus.BUSY), 32'd0);
        check("arst_hi", bus.HI, 32'd0);
        check("arst_lo", bus.LO, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("post_rst_busy", 32'(bus.BUSY), 32'd0);
        check("post_rst_hi", bus.HI, 32'd0);
        check("post_rst_lo", bus.LO, 32'd0);

        // multiply
        run_op(3'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
        check("mult_hi_k", bus.HI, 32'hFFFFFFFF);
        check("mult_lo_k", bus.LO, 32'hFFFFFFFE);
        run_op(3'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
        check("multu_hi_k", bus.HI, 32'h00000001);
        check("multu_lo_k", bus.LO, 32'hFFFFFFFE);

        // divide
        run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        check("div_lo_k", bus.LO, 32'hFFFFFFFD);
        check("div_hi_k", bus.HI, 32'hFFFFFFFF);
        run_op(3'd4, 32'd7, 32'd2, 1'b0);
        check("divu_lo_k", bus.LO, 32'd3);
        check("divu_hi_k", bus.HI, 32'd1);

        // MTHI/MTLO on consecutive cycles
        run_op(3'd5, 32'h12345678, 32'h0, 1'b0);
        check("mthi_k", bus.HI, 32'h12345678);
        run_op(3'd6, 32'h9ABCDEF0, 32'h0, 1'b0);
        check("mtlo_k", bus.LO, 32'h9ABCDEF0);
        check("mt_hi_kept", bus.HI, 32'h12345678);

        // divide by zero leaves HI/LO alone
        run_op(3'd5, 32'hAA, 32'h0, 1'b0);
        run_op(3'd6, 32'hBB, 32'h0, 1'b0);
        run_op(3'd3, 32'h1234, 32'h0, 1'b0);
        check("div0_hi_k", bus.HI, 32'hAA);
        check("div0_lo_k", bus.LO, 32'hBB);
        run_op(3'd4, 32'h1234, 32'h0, 1'b0);

        // signed overflow wraps
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        check("divovf_lo_k", bus.LO, 32'h80000000);
        check("divovf_hi_k", bus.HI, 32'h0);

        // START and operand changes while busy are ignored
        run_op(3'd1, 32'h00012345, 32'hFFFF0003, 1'b1);
        run_op(3'd3, 32'h7FFFFFFF, 32'hFFFFFFFD, 1'b1);

        // random ops, issued back-to-back
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: rb = 32'hFFFFFFFF;
                2: ra = 32'h80000000;
                3: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op(rop, ra, rb, (i % 5) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
